// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit ripple slice per cycle, carry registered between slices.
// Optional subtract mode is enabled by defining CHUNKED_ADDER_SUB_EN.
module chunked_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q, busy_q, done_q, cout_q, ovf_q;

   logic [CHUNK-1:0] a_sl, b_sl;
   logic [CHUNK:0]   slice_d;
   logic             msb_cin_d;
   logic [WIDTH-1:0] acc_d;

   // Current slice: CHUNK-bit add with the registered carry, merged into the accumulator
   always_comb begin
      a_sl      = a_q[idx_q*CHUNK +: CHUNK];
      b_sl      = b_q[idx_q*CHUNK +: CHUNK];
      slice_d   = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry_q);
      msb_cin_d = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_d[CHUNK-1];
      acc_d     = acc_q;
      acc_d[idx_q*CHUNK +: CHUNK] = slice_d[CHUNK-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_q     <= a;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
`ifdef CHUNKED_ADDER_SUB_EN
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub | cin;
`else
                  b_q     <= b;
                  carry_q <= cin;
`endif
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               acc_q   <= acc_d;
               carry_q <= slice_d[CHUNK];
               idx_q   <= idx_q + 1'b1;
               // Last slice publishes the result; outputs are otherwise held
               if (idx_q == LAST) begin
                  idx_q   <= '0;
                  sum_q   <= acc_d;
                  cout_q  <= slice_d[CHUNK];
                  ovf_q   <= msb_cin_d ^ slice_d[CHUNK];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: driver pushes expected results, a monitor checks every done pulse.
module tb_chunked_adder;

   localparam int unsigned W = 16;
   localparam int unsigned C = 4;
   localparam int unsigned N = W / C;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, start, cin, sub;
   logic [W-1:0] a, b;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   mon_en = 1'b0;
   logic rst_at_edge = 1'b1;
   exp_t sb[$];

   chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub  (sub),
`endif
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: result checks on done, busy length, output stability between results
   int           busy_cnt = 0;
   logic [W-1:0] prev_sum = '0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_at_edge) begin
            busy_cnt = 0;
         end else if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sum", 32'(sum), 32'(e.sum));
               chk("cout", 32'(cout), 32'(e.cout));
               chk("ovf", 32'(ovf), 32'(e.ovf));
               chk("latency", 32'(cyc), 32'(e.due));
               chk("busy_cycles", 32'(busy_cnt), 32'(N));
            end
            busy_cnt = 0;
         end else begin
            chk("sum_stable", 32'(sum), 32'(prev_sum));
            if (busy === 1'b1) busy_cnt++;
         end
      end
      prev_sum = sum;
   end

   // Drive a start at the current negedge and record the reference result
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is);
      logic [W-1:0] bb;
      logic [W:0]   full;
      exp_t         e;
      bb     = is ? ~ib : ib;
      full   = {1'b0, ia} + {1'b0, bb} + (W+1)'(is ? 1'b1 : ic);
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (ia[W-1] == bb[W-1]) && (full[W-1] != ia[W-1]);
      e.due  = cyc + 1 + int'(N);
      sb.push_back(e);
      start = 1'b1;
      a     = ia;
      b     = ib;
      cin   = ic;
      sub   = is;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      sub   = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   logic [W-1:0] corner [4];

   initial begin
      corner[0] = 16'hFFFF; corner[1] = 16'h8000; corner[2] = 16'h7FFF; corner[3] = 16'h0000;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_done();
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done();

      // Back-to-back: second start presented while done is high
      issue(16'h7FFF, 16'h0000, 1'b1, 1'b0);
      repeat (N) @(negedge clk);
      chk("b2b_done_seen", 32'(done), 32'd1);
      issue(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_done();

      // Start during RUN must be ignored
      issue(16'h0010, 16'h0020, 1'b0, 1'b0);
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (N + 3) @(negedge clk);

      // Reset on the second RUN edge aborts the operation
      start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      repeat (N + 4) @(negedge clk);
      issue(16'h0003, 16'h0004, 1'b0, 1'b0);
      wait_done();

`ifdef CHUNKED_ADDER_SUB_EN
      issue(16'h0005, 16'h0007, 1'b1, 1'b1);
      wait_done();
      issue(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done();
`endif

      // Randomized traffic, mixing back-to-back and idle gaps
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra, rb;
         logic         rs;
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
`ifdef CHUNKED_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         issue(ra, rb, 1'($urandom), rs);
         repeat (N) @(negedge clk);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      wait_done();
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
